// File: rtl/wb_reg_slice_if.sv
// rtl/wb_reg_slice_if.sv - Wishbone classic bus bundle with master/slave views.
interface wb_reg_slice_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0]   adr;
    logic [DATA_WIDTH-1:0]   dat_w;
    logic [DATA_WIDTH-1:0]   dat_r;
    logic                    we;
    logic [SELECT_WIDTH-1:0] sel;
    logic                    stb;
    logic                    cyc;
    logic                    ack;

    modport master (
        output adr, dat_w, we, sel, stb, cyc,
        input  dat_r, ack
    );

    modport slave (
        input  adr, dat_w, we, sel, stb, cyc,
        output dat_r, ack
    );
endinterface

// File: rtl/wb_reg_slice.sv
// rtl/wb_reg_slice.sv - single-entry Wishbone classic request/response register slice.
// Optional downstream wait timeout enabled by defining WB_REG_SLICE_TIMEOUT_EN.
module wb_reg_slice #(
    parameter int          DATA_WIDTH     = 32,
    parameter int          ADDR_WIDTH     = 32,
    parameter int          SELECT_WIDTH   = DATA_WIDTH / 8,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADBEEF
) (
    input  logic           clk,
    input  logic           rst,
    wb_reg_slice_if.slave  wbm,
    wb_reg_slice_if.master wbs,
    output logic           timeout_o
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [DATA_WIDTH-1:0] TIMEOUT_WORD = DATA_WIDTH'(TIMEOUT_DATA);

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   adr_q;
    logic [DATA_WIDTH-1:0]   dat_w_q;
    logic [DATA_WIDTH-1:0]   dat_r_q;
    logic                    we_q;
    logic [SELECT_WIDTH-1:0] sel_q;
    logic                    stb_q;
    logic                    ack_q;
    logic                    drop_q;
    logic                    timeout_q;
    logic                    drop_now;

    // An upstream that lets cyc fall on the very cycle the slave acks has also abandoned.
    assign drop_now = drop_q | ~wbm.cyc;

`ifdef WB_REG_SLICE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q;
    logic          expire;

    assign expire = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
    wire unused_cfg = ^{TIMEOUT_WORD, TIMEOUT_CYCLES[0]};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            adr_q     <= '0;
            dat_w_q   <= '0;
            dat_r_q   <= '0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            stb_q     <= 1'b0;
            ack_q     <= 1'b0;
            drop_q    <= 1'b0;
            timeout_q <= 1'b0;
`ifdef WB_REG_SLICE_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            ack_q     <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (wbm.cyc && wbm.stb) begin
                        adr_q   <= wbm.adr;
                        dat_w_q <= wbm.dat_w;
                        we_q    <= wbm.we;
                        sel_q   <= wbm.sel;
                        drop_q  <= 1'b0;
                        stb_q   <= 1'b1;
                        state_q <= REQ;
`ifdef WB_REG_SLICE_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end
                end
                REQ: begin
                    if (!wbm.cyc) begin
                        drop_q <= 1'b1;
                    end
                    // Slave ack wins over a timeout expiring in the same cycle.
                    if (wbs.ack) begin
                        dat_r_q <= wbs.dat_r;
                        ack_q   <= ~drop_now;
                        stb_q   <= 1'b0;
                        state_q <= RESP;
                    end
`ifdef WB_REG_SLICE_TIMEOUT_EN
                    else if (expire) begin
                        dat_r_q   <= TIMEOUT_WORD;
                        ack_q     <= ~drop_now;
                        timeout_q <= 1'b1;
                        stb_q     <= 1'b0;
                        state_q   <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    stb_q   <= 1'b0;
                end
            endcase
        end
    end

    assign wbs.adr   = adr_q;
    assign wbs.dat_w = dat_w_q;
    assign wbs.we    = we_q;
    assign wbs.sel   = sel_q;
    assign wbs.stb   = stb_q;
    assign wbs.cyc   = stb_q;
    assign wbm.dat_r = dat_r_q;
    assign wbm.ack   = ack_q;
    assign timeout_o = timeout_q;
endmodule

// File: tb/tb_wb_reg_slice.sv
// tb/tb_wb_reg_slice.sv - self-checking bench for wb_reg_slice.
module tb_wb_reg_slice;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = 4;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        logic [3:0]  sel;
        int          waits;
        logic [31:0] rdata;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic timeout;
    int   tests = 0;
    int   failed = 0;
    int   ack_count = 0;
    int   ack_base;
    logic [31:0] exp_q[$];
    vec_t vecs[4];

    wb_reg_slice_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW)) up ();
    wb_reg_slice_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW)) dn ();

    wb_reg_slice #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW),
        .TIMEOUT_CYCLES(4), .TIMEOUT_DATA(32'hDEADBEEF)
    ) dut (
        .clk(clk), .rst(rst), .wbm(up.slave), .wbs(dn.master), .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every upstream ack must match the oldest expected read word.
    always @(negedge clk) begin
        if (up.ack === 1'b1) begin
            ack_count++;
            if (exp_q.size() == 0) check("spurious_ack", {63'b0, up.ack}, 64'd0);
            else check("rdata", up.dat_r, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [31:0] adr, input logic [31:0] dat,
                             input logic we, input logic [3:0] sel);
        up.adr = adr; up.dat_w = dat; up.we = we; up.sel = sel;
        up.cyc = 1'b1; up.stb = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stb"}, dn.stb, 0);
        check({tag, "_cyc"}, dn.cyc, 0);
        check({tag, "_adr"}, dn.adr, 0);
        check({tag, "_datw"}, dn.dat_w, 0);
        check({tag, "_we"}, dn.we, 0);
        check({tag, "_sel"}, dn.sel, 0);
        check({tag, "_ack"}, up.ack, 0);
        check({tag, "_datr"}, up.dat_r, 0);
        check({tag, "_tmo"}, timeout, 0);
    endtask

    task automatic do_txn(input vec_t v);
        tick();
        drive_req(v.adr, v.dat, v.we, v.sel);
        exp_q.push_back(v.rdata);
        for (int k = 1; k <= 2 + v.waits; k++) begin
            tick();
            dn.ack   = (k == 1 + v.waits);
            dn.dat_r = dn.ack ? v.rdata : 32'hBAD0BAD0;
            @(negedge clk);
            if (k <= 1 + v.waits) begin
                check("req_stb", dn.stb, 1);
                check("req_cyc", dn.cyc, 1);
                check("req_adr", dn.adr, v.adr);
                check("req_datw", dn.dat_w, v.dat);
                check("req_we", dn.we, v.we);
                check("req_sel", dn.sel, v.sel);
                check("early_ack", up.ack, 0);
            end else begin
                check("resp_stb", dn.stb, 0);
                check("resp_ack", up.ack, 1);
                check("resp_tmo", timeout, 0);
            end
        end
        tick();
        up.cyc = 1'b0; up.stb = 1'b0;
        @(negedge clk);
        check("ack_once", up.ack, 0);
        check("hold_datr", up.dat_r, v.rdata);
        check("idle_stb", dn.stb, 0);
    endtask

    initial begin
        vecs[0] = '{adr: 32'h0000_1000, dat: 32'h0,         we: 1'b0, sel: 4'hF,    waits: 0, rdata: 32'hCAFEF00D};
        vecs[1] = '{adr: 32'h0000_2004, dat: 32'h12345678,  we: 1'b1, sel: 4'b0011, waits: 3, rdata: 32'h0000_0000};
        vecs[2] = '{adr: 32'hFFFF_FFFC, dat: 32'h0,         we: 1'b0, sel: 4'hF,    waits: 1, rdata: 32'hA5A55A5A};
        vecs[3] = '{adr: 32'h0000_0000, dat: 32'hFFFFFFFF,  we: 1'b1, sel: 4'b1000, waits: 2, rdata: 32'h11111111};

        rst = 1'b1;
        up.adr = '0; up.dat_w = '0; up.we = 1'b0; up.sel = '0; up.cyc = 1'b0; up.stb = 1'b0;
        dn.dat_r = '0; dn.ack = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        tick();
        rst = 1'b0;

        for (int i = 0; i < 4; i++) do_txn(vecs[i]);

        // Back-to-back: master keeps stb high through RESP and presents a new request.
        ack_base = ack_count;
        tick();
        drive_req(32'h3000, 32'h0, 1'b0, 4'hF);
        exp_q.push_back(32'h01020304);
        tick(); dn.ack = 1'b1; dn.dat_r = 32'h01020304;
        @(negedge clk); check("b2b_stb1", dn.stb, 1);
        tick(); dn.ack = 1'b0; dn.dat_r = 32'hBAD0BAD0;
        @(negedge clk); check("b2b_ack1", up.ack, 1);
        tick(); up.adr = 32'h3004;
        exp_q.push_back(32'h05060708);
        @(negedge clk); check("b2b_gap_stb", dn.stb, 0); check("b2b_gap_ack", up.ack, 0);
        tick(); dn.ack = 1'b1; dn.dat_r = 32'h05060708;
        @(negedge clk); check("b2b_stb2", dn.stb, 1); check("b2b_adr2", dn.adr, 32'h3004);
        tick(); dn.ack = 1'b0;
        @(negedge clk); check("b2b_ack2", up.ack, 1);
        tick(); up.cyc = 1'b0; up.stb = 1'b0;
        repeat (3) begin
            @(negedge clk); check("b2b_quiet", up.ack, 0);
            tick();
        end
        check("b2b_count", ack_count - ack_base, 2);

        // Abandon: upstream drops cyc in REQ, slave acks two cycles later.
        ack_base = ack_count;
        drive_req(32'h4000, 32'h55AA, 1'b1, 4'hF);
        tick(); up.cyc = 1'b0; up.stb = 1'b0;
        @(negedge clk); check("abn_stb1", dn.stb, 1);
        tick();
        @(negedge clk); check("abn_stb2", dn.stb, 1);
        tick(); dn.ack = 1'b1; dn.dat_r = 32'h77;
        @(negedge clk); check("abn_stb3", dn.stb, 1);
        tick(); dn.ack = 1'b0;
        @(negedge clk); check("abn_resp_ack", up.ack, 0); check("abn_resp_stb", dn.stb, 0);
        tick();
        @(negedge clk); check("abn_count", ack_count - ack_base, 0);

`ifdef WB_REG_SLICE_TIMEOUT_EN
        tick();
        drive_req(32'h5000, 32'h0, 1'b0, 4'hF);
        exp_q.push_back(32'hDEADBEEF);
        for (int k = 1; k <= 4; k++) begin
            tick();
            @(negedge clk);
            check("tmo_stb", dn.stb, 1);
            check("tmo_early_ack", up.ack, 0);
            check("tmo_early", timeout, 0);
        end
        tick();
        @(negedge clk);
        check("tmo_ack", up.ack, 1);
        check("tmo_pulse", timeout, 1);
        check("tmo_stb_drop", dn.stb, 0);
        tick(); up.cyc = 1'b0; up.stb = 1'b0;
        @(negedge clk);
        check("tmo_pulse_end", timeout, 0);
        check("tmo_hold", up.dat_r, 32'hDEADBEEF);
`endif

        // Hung slave, then reset in the middle of REQ.
        tick();
        drive_req(32'h6000, 32'hABCD, 1'b1, 4'h3);
`ifdef WB_REG_SLICE_TIMEOUT_EN
        for (int k = 0; k < 2; k++) begin
`else
        for (int k = 0; k < 20; k++) begin
`endif
            tick();
            @(negedge clk);
            check("hang_stb", dn.stb, 1);
            check("hang_ack", up.ack, 0);
        end
        tick(); rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        tick(); rst = 1'b0; up.cyc = 1'b0; up.stb = 1'b0;
        repeat (3) begin
            @(negedge clk); check("post_rst_ack", up.ack, 0);
            tick();
        end

        do_txn(vecs[0]);
        check("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
